rep_seq_monitor: RTL and testbench

//  Synthesizable run-time checker for the repetition-operator properties on a/b/c.
//  On each $rose(a) it evaluates one of three sequences:
//    b[*N] ##1 c, b[->MIN:MAX] ##1 c, or b[=N] ##1 c,

---
 rtl/rep_seq_pkg.sv | 35 +++
 rtl/rep_seq_monitor_sat_counter.sv | 24 ++
 rtl/rep_seq_monitor.sv | 176 +++++++++++++++++
 tb/tb_rep_seq_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_seq_pkg.sv
// Shared types and helpers for the repetition-sequence monitor.
// Holds mode/state/fail-code encodings and the saturating increment.
package rep_seq_pkg;

  typedef enum logic [1:0] {
    CONSEC    = 2'd0,
    GOTO      = 2'd1,
    NONCONSEC = 2'd2,
    RSVD      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    MATCH = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_B_BREAK   = 3'd1,
    FC_C_MISSING = 3'd2,
    FC_EXTRA_B   = 3'd3,
    FC_TIMEOUT   = 3'd4,
    FC_BAD_CFG   = 3'd5
  } fail_code_e;

  localparam int SAT_W = 32;

  // Callers narrower than SAT_W zero-extend in and truncate the result back.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rep_seq_monitor_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, holds at all-ones.
// Single-cycle update, no backpressure; async active-high reset clears it.
module sat_counter
  import rep_seq_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [SW-1:0] cnt
);

  localparam logic [SW-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= SW'(sat_inc(SAT_W'(cnt), SAT_W'(CNT_MAX)));
    end
  end

endmodule

// File: rtl/rep_seq_monitor.sv
// Run-time checker for b[*N] ##1 c, b[->MIN:MAX] ##1 c and b[=N] ##1 c after $rose(a).
// Verdict pulses one cycle after the deciding edge; no backpressure, triggers while busy are dropped.
module rep_seq_monitor
  import rep_seq_pkg::*;
#(
  parameter int CW      = 4,
  parameter int TIMEOUT = 64,
  parameter int SW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  input  logic          c,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] rep_n,
  input  logic [CW-1:0] rep_min,
  input  logic [CW-1:0] rep_max,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic [2:0]    fail_code,
  output logic [SW-1:0] pass_cnt,
  output logic [SW-1:0] fail_cnt,
  output logic [SW-1:0] drop_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state, state_nxt;
  mode_e         mode_q;
  logic          a_q, bad_q, cfg_bad;
  logic [CW-1:0] n_q, min_q, max_q;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          armed, armed_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          pass_nxt, fail_nxt;
  fail_code_e    code_nxt;
  logic          rose, trig, drop;

  assign rose = a & ~a_q;
  assign trig = rose & (state == IDLE);
  assign drop = rose & (state != IDLE);
  assign busy = (state != IDLE);

  always_comb begin
    cfg_bad = 1'b0;
    case (mode_e'(mode))
      CONSEC, NONCONSEC: cfg_bad = (rep_n == '0);
      GOTO:              cfg_bad = (rep_min == '0) || (rep_min > rep_max);
      default:           cfg_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + CW'(1);
    armed_nxt = armed;
    tmo_nxt   = tmo_cnt;
    pass_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    code_nxt  = FC_NONE;
    case (state)
      IDLE: if (trig) state_nxt = GAP;
      GAP: begin
        cnt_nxt   = '0;
        armed_nxt = 1'b0;
        tmo_nxt   = '0;
        if (bad_q) begin
          fail_nxt  = 1'b1;
          code_nxt  = FC_BAD_CFG;
          state_nxt = IDLE;
        end else begin
          state_nxt = MATCH;
        end
      end
      MATCH: begin
        tmo_nxt = tmo_cnt + TW'(1);
        case (mode_q)
          CONSEC: begin
            if (cnt == n_q) begin
              pass_nxt = c;
              fail_nxt = ~c;
              code_nxt = c ? FC_NONE : FC_C_MISSING;
            end else if (b) begin
              cnt_nxt = cnt_inc;
            end else begin
              fail_nxt = 1'b1;
              code_nxt = FC_B_BREAK;
            end
          end
          GOTO: begin
            if (armed && c) begin
              pass_nxt = 1'b1;
            end else if (armed && (cnt == max_q)) begin
              fail_nxt = 1'b1;
              code_nxt = FC_C_MISSING;
            end else begin
              // A missed c disarms, but this edge's b still counts and may re-arm.
              armed_nxt = 1'b0;
              if (b) begin
                cnt_nxt   = cnt_inc;
                armed_nxt = (cnt_inc >= min_q) && (cnt_inc <= max_q);
              end
            end
          end
          NONCONSEC: begin
            if (armed) begin
              if (c) begin
                pass_nxt = 1'b1;
              end else if (b) begin
                fail_nxt = 1'b1;
                code_nxt = FC_EXTRA_B;
              end
            end else if (b) begin
              cnt_nxt   = cnt_inc;
              armed_nxt = (cnt_inc == n_q);
            end
          end
          default: begin
            fail_nxt = 1'b1;
            code_nxt = FC_BAD_CFG;
          end
        endcase
        if ((TIMEOUT != 0) && (mode_q != CONSEC) && !pass_nxt && !fail_nxt &&
            (tmo_cnt == TMO_LAST)) begin
          fail_nxt = 1'b1;
          code_nxt = FC_TIMEOUT;
        end
        if (pass_nxt || fail_nxt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= 1'b0;
      mode_q    <= CONSEC;
      n_q       <= '0;
      min_q     <= '0;
      max_q     <= '0;
      bad_q     <= 1'b0;
      cnt       <= '0;
      armed     <= 1'b0;
      tmo_cnt   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 3'd0;
    end else begin
      a_q       <= a;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      armed     <= armed_nxt;
      tmo_cnt   <= tmo_nxt;
      pass      <= pass_nxt;
      fail      <= fail_nxt;
      fail_code <= code_nxt;
      if (trig) begin
        mode_q <= mode_e'(mode);
        n_q    <= rep_n;
        min_q  <= rep_min;
        max_q  <= rep_max;
        bad_q  <= cfg_bad;
      end
    end
  end

  sat_counter #(.SW(SW)) u_pass_cnt (.clk(clk), .rst(rst), .inc(pass_nxt), .cnt(pass_cnt));
  sat_counter #(.SW(SW)) u_fail_cnt (.clk(clk), .rst(rst), .inc(fail_nxt), .cnt(fail_cnt));
  sat_counter #(.SW(SW)) u_drop_cnt (.clk(clk), .rst(rst), .inc(drop),     .cnt(drop_cnt));

endmodule

// File: tb/tb_rep_seq_monitor.sv
// Bench for rep_seq_monitor: vector table plus hand-built overlap/reset/saturation sequences.
module tb_rep_seq_monitor;

  localparam int SW_TB   = 4;
  localparam int CNT_MAX = (1 << SW_TB) - 1;

  logic             clk, rst, a, b, c;
  logic [1:0]       mode;
  logic [3:0]       rep_n, rep_min, rep_max;
  logic             busy, pass, fail;
  logic [2:0]       fail_code;
  logic [SW_TB-1:0] pass_cnt, fail_cnt, drop_cnt;

  rep_seq_monitor #(.CW(4), .TIMEOUT(64), .SW(SW_TB)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .mode(mode),
    .rep_n(rep_n), .rep_min(rep_min), .rep_max(rep_max),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  n, mn, mx;
    logic [15:0] bs, cs;   // bit k drives edge T+2+k
    int          len;
    bit          exp_pass;
    logic [2:0]  exp_code;
    int          off;      // deciding edge minus trigger edge
  } vec_t;

  typedef struct {
    bit         is_pass;
    logic [2:0] code;
    int         edge_no;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   edge_n = 0;
  int   exp_pc = 0, exp_fc = 0, exp_dc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic int sat(int v);
    return (v >= CNT_MAX) ? v : v + 1;
  endfunction

  function automatic void add(logic [1:0] m, logic [3:0] n, logic [3:0] mn, logic [3:0] mx,
                              logic [15:0] bs, logic [15:0] cs, int len, bit p,
                              logic [2:0] code, int off);
    vec_t v;
    v.mode = m; v.n = n; v.mn = mn; v.mx = mx; v.bs = bs; v.cs = cs;
    v.len = len; v.exp_pass = p; v.exp_code = code; v.off = off;
    vecs.push_back(v);
  endfunction

  function automatic void expect_verdict(bit p, logic [2:0] code, int edge_no);
    exp_t e;
    e.is_pass = p; e.code = code; e.edge_no = edge_no;
    sb.push_back(e);
    if (p) exp_pc = sat(exp_pc);
    else   exp_fc = sat(exp_fc);
  endfunction

  // Scoreboard: every verdict pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (pass || fail)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_verdict: pass=%0b fail=%0b code=%0d at edge %0d, none required",
                 pass, fail, fail_code, edge_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("verdict_pass", pass, e.is_pass);
        chk("verdict_fail", fail, !e.is_pass);
        if (!e.is_pass) chk("verdict_code", fail_code, e.code);
        chk("verdict_edge", edge_n, e.edge_no);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d verdicts outstanding, required 0", sb.size());
      sb.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_counters(string tag);
    chk({tag, "_pass_cnt"}, pass_cnt, exp_pc);
    chk({tag, "_fail_cnt"}, fail_cnt, exp_fc);
    chk({tag, "_drop_cnt"}, drop_cnt, exp_dc);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    mode = v.mode; rep_n = v.n; rep_min = v.mn; rep_max = v.mx;
    a = 1'b1; b = 1'b0; c = 1'b0;
    expect_verdict(v.exp_pass, v.exp_code, edge_n + 1 + v.off);
    tick();                                    // edge T
    a = 1'b0;
    mode = 2'd3; rep_n = 4'd0; rep_min = 4'd0; rep_max = 4'd0;  // must be ignored now
    tick();                                    // edge T+1
    for (int k = 0; k < v.len; k++) begin
      b = v.bs[k];
      c = v.cs[k];
      tick();
    end
    b = 1'b0; c = 1'b0;
    drain();
    check_counters($sformatf("vec%0d", idx));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t pv;
    //  mode  N     MIN   MAX   b bits            c bits            len pass code off
    add(2'd0, 4'd3, 4'd0, 4'd0, 16'b0111,         16'b1000,         4, 1, 3'd0, 5);
    add(2'd0, 4'd3, 4'd0, 4'd0, 16'b011,          16'b0,            3, 0, 3'd1, 4);
    add(2'd0, 4'd3, 4'd0, 4'd0, 16'b0111,         16'b0,            4, 0, 3'd2, 5);
    add(2'd2, 4'd2, 4'd0, 4'd0, 16'b0000101,      16'b1000000,      7, 1, 3'd0, 8);
    add(2'd2, 4'd2, 4'd0, 4'd0, 16'b10101,        16'b0,            5, 0, 3'd3, 6);
    add(2'd1, 4'd0, 4'd2, 4'd4, 16'b011011,       16'b0,            6, 0, 3'd2, 7);
    add(2'd1, 4'd0, 4'd2, 4'd4, 16'b011,          16'b100,          3, 1, 3'd0, 4);
    add(2'd1, 4'd0, 4'd3, 4'd2, 16'b0,            16'b0,            0, 0, 3'd5, 1);
    add(2'd3, 4'd3, 4'd1, 4'd3, 16'b0,            16'b0,            0, 0, 3'd5, 1);
    add(2'd0, 4'd0, 4'd1, 4'd3, 16'b0,            16'b0,            0, 0, 3'd5, 1);
    add(2'd1, 4'd3, 4'd0, 4'd3, 16'b0,            16'b0,            0, 0, 3'd5, 1);
    add(2'd2, 4'd0, 4'd1, 4'd3, 16'b0,            16'b0,            0, 0, 3'd5, 1);
    add(2'd2, 4'd1, 4'd0, 4'd0, 16'b110,          16'b101,          3, 1, 3'd0, 4);
    add(2'd1, 4'd0, 4'd1, 4'd1, 16'b01,           16'b10,           2, 1, 3'd0, 3);
    add(2'd0, 4'd2, 4'd0, 4'd0, 16'b011,          16'b101,          3, 1, 3'd0, 4);
    add(2'd1, 4'd0, 4'd2, 4'd3, 16'b0111,         16'b0,            4, 0, 3'd2, 5);
    add(2'd2, 4'd1, 4'd0, 4'd0, 16'b0,            16'b0,            0, 0, 3'd4, 65);

    // Reset state, then a=1 already high at the first edge after reset counts as a rose.
    rst = 1'b1; a = 1'b1; b = 1'b0; c = 1'b0;
    mode = 2'd0; rep_n = 4'd1; rep_min = 4'd0; rep_max = 4'd0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_code", fail_code, 0);
    check_counters("rst");
    tick();
    rst = 1'b0;
    expect_verdict(1'b1, 3'd0, edge_n + 1 + 3);
    tick();                                    // T
    chk("first_edge_busy", busy, 1);
    a = 1'b0;
    tick();                                    // T+1
    b = 1'b1;
    tick();                                    // T+2
    b = 1'b0; c = 1'b1;
    tick();                                    // T+3
    c = 1'b0;
    drain();
    check_counters("first");

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Rose of a mid-attempt and on the verdict edge: both dropped, one verdict only.
    mode = 2'd0; rep_n = 4'd3; a = 1'b1;
    expect_verdict(1'b1, 3'd0, edge_n + 1 + 5);
    tick();                                    // T
    chk("ovl_busy_start", busy, 1);
    a = 1'b0;
    tick();                                    // T+1
    b = 1'b1;
    tick();                                    // T+2
    a = 1'b1;
    tick();                                    // T+3, dropped
    a = 1'b0;
    tick();                                    // T+4
    b = 1'b0; c = 1'b1; a = 1'b1;
    tick();                                    // T+5, verdict edge, dropped
    chk("ovl_busy_after_verdict", busy, 0);
    exp_dc = 2;
    a = 1'b0; c = 1'b0;
    drain();
    check_counters("ovl");

    // Async reset mid-MATCH aborts without a pulse and clears counters.
    mode = 2'd2; rep_n = 4'd2; a = 1'b1;
    tick();                                    // T
    a = 1'b0;
    tick();                                    // T+1
    b = 1'b1;
    tick();                                    // T+2
    b = 1'b0;
    tick();                                    // T+3
    chk("mid_busy_before_rst", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_pc = 0; exp_fc = 0; exp_dc = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_fail", fail, 0);
    check_counters("mid_rst");
    tick();
    rst = 1'b0;
    b = 1'b1; c = 1'b1;
    repeat (6) tick();
    b = 1'b0; c = 1'b0;
    chk("post_rst_busy", busy, 0);
    check_counters("post_rst");

    // Saturation: one more pass than the counter can hold.
    pv.mode = 2'd0; pv.n = 4'd1; pv.mn = 4'd0; pv.mx = 4'd0;
    pv.bs = 16'b01; pv.cs = 16'b10; pv.len = 2;
    pv.exp_pass = 1'b1; pv.exp_code = 3'd0; pv.off = 3;
    for (int i = 0; i <= CNT_MAX; i++) run_vec(pv, 100 + i);
    chk("pass_cnt_saturated", pass_cnt, CNT_MAX);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
